// File: rtl/alu_issuer.sv
// ---------------------------------------------------------------------------
// alu_issuer
//
// Initiator side of the 32-bit combinational ALU. Commands are queued in a
// small FIFO, the FIFO head is registered onto the ALU operand/opcode inputs,
// and the ALU result is captured and returned in order on a valid/ready
// result channel. An accumulator register tracks the most recent result
// produced by a legal opcode.
//
// Optional feature (macro ALU_ISSUE_ACC_EN):
//   defined     - cmd_use_acc is stored per entry; when set, the accumulator
//                 replaces operand A at issue.
//   not defined - cmd_use_acc is ignored; operand A is always the stored A.
//
// Parameters:
//   DEPTH  command FIFO depth (power of two, >= 2)
//   PTR_W  FIFO pointer width, log2(DEPTH)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    FIFO not full
//   cmd_a/b      operands
//   cmd_op       opcode (000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra)
//   cmd_use_acc  use accumulator as operand A (ALU_ISSUE_ACC_EN only)
//   alu_a/b/op   registered ALU inputs
//   alu_c        ALU result (combinational from alu_a/b/op)
//   res_valid    result available
//   res_ready    consumer accepts result
//   res_data     registered result
//   res_err      result came from an illegal opcode (11x)
// ---------------------------------------------------------------------------
module alu_issuer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic        cmd_use_acc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [1:0]       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      acc;

    logic [31:0] mem_a  [DEPTH];
    logic [31:0] mem_b  [DEPTH];
    logic [2:0]  mem_op [DEPTH];

    logic        push;
    logic        pop_en;
    logic [31:0] head_a;
    logic        illegal_op;

    assign cmd_ready  = (count != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    // A new command may issue from IDLE, or from HOLD in the same edge that
    // the pending result is consumed.
    assign pop_en     = (count != '0) &&
                        ((state == IDLE) || ((state == HOLD) && res_ready));
    assign illegal_op = (alu_op[2:1] == 2'b11);

    // FIFO storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

`ifdef ALU_ISSUE_ACC_EN
    logic mem_acc [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_acc[wr_ptr] <= cmd_use_acc;
        end
    end

    // EXEC (the only accumulator writer) never coincides with a pop, so the
    // registered accumulator is always the last committed result here.
    assign head_a = mem_acc[rd_ptr] ? acc : mem_a[rd_ptr];
`else
    logic unused_acc_bits;

    assign unused_acc_bits = ^{cmd_use_acc, acc};
    assign head_a          = mem_a[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            acc       <= '0;
        end else begin
            if (pop_en) begin
                alu_a  <= head_a;
                alu_b  <= mem_b[rd_ptr];
                alu_op <= mem_op[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (pop_en) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_c;
                    res_err   <= illegal_op;
                    res_valid <= 1'b1;
                    if (!illegal_op) begin
                        acc <= alu_c;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop_en ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_issuer
//
// Self-checking bench for alu_issuer. Provides a behavioural stand-in for the
// combinational ALU, keeps an in-order queue of expected results computed at
// command acceptance, and compares every presented result against it.
// Directed sequences add hand-computed literal expectations (latency, order,
// backpressure, illegal opcode, reset discard, accumulator use).
// ---------------------------------------------------------------------------
module tb_alu_issuer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic        cmd_use_acc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] modelAcc;
    logic [31:0] modelA;
    exp_t        modelEntry;

    alu_issuer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU semantics: shifts are unmasked, illegal opcodes yield zero.
    function automatic logic [31:0] aluFn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a >> b;
            3'b101:  return 32'($signed(a) >>> b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_c = aluFn(alu_a, alu_b, alu_op);

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic useAcc);
        bit accepted = 0;
        cmd_a       = a;
        cmd_b       = b;
        cmd_op      = op;
        cmd_use_acc = useAcc;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (cmd_ready) accepted = 1;
            stepClk();
        end
        cmd_valid = 1'b0;
        if (!accepted) checkOutput("push timeout", 32'd0, 32'd1);
    endtask

    task automatic waitResult(string name, logic [31:0] expData, logic expErr);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            stepClk();
            if (res_valid) seen = 1;
        end
        if (!seen) begin
            checkOutput({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, " data"}, res_data, expData);
            checkOutput({name, " err"}, 32'(res_err), 32'(expErr));
        end
    endtask

    // Scoreboard: compares each presented result with the model, then
    // records newly accepted commands for the coming edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (res_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious result", 32'(res_valid), 32'd0);
                end else begin
                    checkOutput("model data", res_data, expQ[0].data);
                    checkOutput("model err", 32'(res_err), 32'(expQ[0].err));
                    if (res_ready) void'(expQ.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                modelA = cmd_a;
`ifdef ALU_ISSUE_ACC_EN
                if (cmd_use_acc) modelA = modelAcc;
`endif
                modelEntry.data = aluFn(modelA, cmd_b, cmd_op);
                modelEntry.err  = (cmd_op[2:1] == 2'b11);
                if (!modelEntry.err) modelAcc = modelEntry.data;
                expQ.push_back(modelEntry);
            end
        end else begin
            expQ.delete();
            modelAcc = 32'd0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  nres;
        int  lastCyc;
        bit  accept;
        logic [31:0] vecA  [5] = '{32'd10, 32'h0000F0F0, 32'h000000F0, 32'h80000000, 32'h80000000};
        logic [31:0] vecB  [5] = '{32'd3,  32'h0000FF00, 32'h0000000F, 32'd40,       32'd32};
        logic [2:0]  vecOp [5] = '{3'b001, 3'b010,       3'b011,       3'b101,       3'b100};
        logic [31:0] vecExp[5] = '{32'd7,  32'h0000F000, 32'h000000FF, 32'hFFFFFFFF, 32'd0};

        reset = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_use_acc = 1'b0; res_ready = 1'b0;
        repeat (2) stepClk();
        checkOutput("reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset alu_a", alu_a, 32'd0);
        checkOutput("reset alu_op", 32'(alu_op), 32'd0);
        checkOutput("reset res_data", res_data, 32'd0);
        checkOutput("reset res_err", 32'(res_err), 32'd0);
        reset = 1'b1;
        res_ready = 1'b1;
        stepClk();

        // Latency: accepted at N, issued at N+1, valid after N+2.
        applyStimulus(32'd5, 32'd3, 3'b000, 1'b0);
        checkOutput("lat N valid", 32'(res_valid), 32'd0);
        stepClk();
        checkOutput("lat N+1 alu_a", alu_a, 32'd5);
        checkOutput("lat N+1 alu_b", alu_b, 32'd3);
        checkOutput("lat N+1 valid", 32'(res_valid), 32'd0);
        stepClk();
        checkOutput("lat N+2 valid", 32'(res_valid), 32'd1);
        checkOutput("lat N+2 data", res_data, 32'd8);
        checkOutput("lat N+2 err", 32'(res_err), 32'd0);
        stepClk();
        checkOutput("lat N+3 valid", 32'(res_valid), 32'd0);

        // Shifts, in order.
        applyStimulus(32'h80000000, 32'd4, 3'b101, 1'b0);
        applyStimulus(32'h80000000, 32'd4, 3'b100, 1'b0);
        waitResult("sra", 32'hF8000000, 1'b0);
        waitResult("srl", 32'h08000000, 1'b0);

        // Remaining opcodes and oversized shift amounts.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecA[i], vecB[i], vecOp[i], 1'b0);
            waitResult("vector", vecExp[i], 1'b0);
        end
        stepClk();

        // Backpressure: one held result, four queued, sixth stalls.
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(32'(i), 32'(i), 3'b000, 1'b0);
        checkOutput("full cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("hold valid", 32'(res_valid), 32'd1);
        cmd_a = 32'd6; cmd_b = 32'd6; cmd_op = 3'b000; cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) stepClk();
        checkOutput("stall cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("hold data", res_data, 32'd2);
        res_ready = 1'b1;
        nres = 0;
        lastCyc = -1;
        for (int cyc = 0; cyc < 30 && nres < 6; cyc++) begin
            if (res_valid) begin
                checkOutput("burst data", res_data, 32'(2 * (nres + 1)));
                if (nres > 0) checkOutput("burst spacing", 32'(cyc - lastCyc), 32'd2);
                lastCyc = cyc;
                nres++;
            end
            accept = cmd_valid && cmd_ready;
            stepClk();
            if (accept) cmd_valid = 1'b0;
        end
        checkOutput("burst count", 32'(nres), 32'd6);

        // Illegal opcode; accumulator must still hold 12 afterwards.
        applyStimulus(32'd7, 32'd9, 3'b110, 1'b0);
        waitResult("illegal", 32'd0, 1'b1);
        applyStimulus(32'd100, 32'd0, 3'b000, 1'b1);
`ifdef ALU_ISSUE_ACC_EN
        waitResult("acc after illegal", 32'd12, 1'b0);
`else
        waitResult("use_acc ignored", 32'd100, 1'b0);
`endif
        stepClk();

        // Reset while a result is held and two commands are queued.
        res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) applyStimulus(32'(i), 32'd1, 3'b000, 1'b0);
        checkOutput("pre-reset valid", 32'(res_valid), 32'd1);
        reset = 1'b0;
        stepClk();
        checkOutput("post-reset valid", 32'(res_valid), 32'd0);
        checkOutput("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stepClk();
            checkOutput("discarded stays quiet", 32'(res_valid), 32'd0);
        end

        // Accumulator chaining (accumulator cleared by reset).
        applyStimulus(32'd10, 32'd5, 3'b000, 1'b0);
        applyStimulus(32'd0, 32'd3, 3'b001, 1'b1);
        waitResult("chain first", 32'd15, 1'b0);
`ifdef ALU_ISSUE_ACC_EN
        waitResult("chain second", 32'd12, 1'b0);
`else
        waitResult("chain second", 32'hFFFFFFFD, 1'b0);
`endif

        repeat (6) stepClk();
        checkOutput("queue drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
